ps2_host_tx: RTL and testbench

Host-to-device PS/2 transmitter. It sends one command byte (LED update 0xED, reset 0xFF, typematic 0xF3, and so on) to the keyboard over the same open-drain `ps2_clock`/`ps2_data` pair that the scan-code receive path uses. It runs the inhibit / request-to-send sequence, shifts 8 data bits LSB-first plus odd parity and stop on device-generated clock edges, then checks the device line-ACK. `tx_active` lets the receive path ignore bus activity it did not originate.

---
 rtl/ps2_pkg.sv | 26 ++
 rtl/ps2_line_sync.sv | 32 +++
 rtl/ps2_host_tx.sv | 133 +++++++++++++
 tb/tb_ps2_host_tx.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// ps2_pkg: shared PS/2 state type, command/response codes and frame builder
package ps2_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INHIBIT,
        ST_RTS,
        ST_SHIFT,
        ST_ACK,
        ST_WAIT_IDLE,
        ST_DONE,
        ST_ERR
    } ps2_tx_state_t;

    localparam logic [7:0] PS2_CMD_SET_LEDS  = 8'hED;
    localparam logic [7:0] PS2_CMD_RESET     = 8'hFF;
    localparam logic [7:0] PS2_CMD_TYPEMATIC = 8'hF3;
    localparam logic [7:0] PS2_RSP_ACK       = 8'hFA;
    localparam logic [7:0] PS2_RSP_RESEND    = 8'hFE;

    // stop, odd parity, data; shifted out LSB first
    function automatic logic [9:0] ps2_frame(input logic [7:0] d);
        return {1'b1, ~^d, d};
    endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// ps2_line_sync: 2-FF synchronizer for the PS/2 clock and data lines plus a falling-edge strobe
module ps2_line_sync (
    input  logic inclock,
    input  logic resetn,
    input  logic clock_in,
    input  logic data_in,
    output logic clock_sync,
    output logic data_sync,
    output logic fe
);
    logic [1:0] clk_ff;
    logic [1:0] dat_ff;
    logic       clk_prev;

    // lines idle high, so the stages reset to 1 to avoid a false edge after reset
    always_ff @(posedge inclock or negedge resetn) begin
        if (!resetn) begin
            clk_ff   <= 2'b11;
            dat_ff   <= 2'b11;
            clk_prev <= 1'b1;
        end else begin
            clk_ff   <= {clk_ff[0], clock_in};
            dat_ff   <= {dat_ff[0], data_in};
            clk_prev <= clk_ff[1];
        end
    end

    assign clock_sync = clk_ff[1];
    assign data_sync  = dat_ff[1];
    assign fe         = clk_prev & ~clk_ff[1];

endmodule

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: host-to-device PS/2 command transmitter with inhibit/RTS and line-ACK check
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int TIMEOUT_CYCLES = 750000
) (
    input  logic       inclock,
    input  logic       resetn,
    input  logic [7:0] cmd_data,
    input  logic       cmd_send,
    output logic       cmd_busy,
    output logic       cmd_done,
    output logic       cmd_error,
    output logic       tx_active,
    inout  wire        ps2_clock,
    inout  wire        ps2_data
);
    localparam int IW = $clog2(INHIBIT_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    ps2_tx_state_t state;
    logic [9:0]    shreg;
    logic [3:0]    bitcnt;
    logic [IW-1:0] inh_cnt;
    logic [TW-1:0] to_cnt;
    logic          idle_seen;
    logic          clk_oe;
    logic          dat_oe;
    logic          clock_sync;
    logic          data_sync;
    logic          fe;
    logic          counting;
    logic          timeout;

    ps2_line_sync u_sync (
        .inclock    (inclock),
        .resetn     (resetn),
        .clock_in   (ps2_clock),
        .data_in    (ps2_data),
        .clock_sync (clock_sync),
        .data_sync  (data_sync),
        .fe         (fe)
    );

    assign ps2_clock = clk_oe ? 1'b0 : 1'bz;
    assign ps2_data  = dat_oe ? 1'b0 : 1'bz;
    assign tx_active = cmd_busy;
    assign counting  = state inside {ST_SHIFT, ST_ACK, ST_WAIT_IDLE};
    assign timeout   = !fe && to_cnt == TW'(TIMEOUT_CYCLES - 1);

    // transmit sequencer; a device edge always beats a coincident timeout
    always_ff @(posedge inclock or negedge resetn) begin
        if (!resetn) begin
            state     <= ST_IDLE;
            shreg     <= '0;
            bitcnt    <= '0;
            inh_cnt   <= '0;
            to_cnt    <= '0;
            idle_seen <= 1'b0;
            clk_oe    <= 1'b0;
            dat_oe    <= 1'b0;
            cmd_busy  <= 1'b0;
            cmd_done  <= 1'b0;
            cmd_error <= 1'b0;
        end else begin
            cmd_done  <= 1'b0;
            cmd_error <= 1'b0;
            if (counting)
                to_cnt <= fe ? '0 : (to_cnt == TW'(TIMEOUT_CYCLES) ? to_cnt : to_cnt + 1'b1);
            case (state)
                ST_IDLE: if (cmd_send) begin
                    shreg     <= ps2_frame(cmd_data);
                    bitcnt    <= '0;
                    inh_cnt   <= '0;
                    to_cnt    <= '0;
                    idle_seen <= 1'b0;
                    clk_oe    <= 1'b1;
                    cmd_busy  <= 1'b1;
                    state     <= ST_INHIBIT;
                end
                ST_INHIBIT: if (inh_cnt == IW'(INHIBIT_CYCLES - 1)) begin
                    dat_oe <= 1'b1;
                    state  <= ST_RTS;
                end else begin
                    inh_cnt <= inh_cnt + 1'b1;
                end
                ST_RTS: begin
                    clk_oe <= 1'b0;
                    to_cnt <= '0;
                    state  <= ST_SHIFT;
                end
                ST_SHIFT: if (fe) begin
                    dat_oe <= ~shreg[0];
                    shreg  <= {1'b0, shreg[9:1]};
                    bitcnt <= bitcnt + 4'd1;
                    state  <= bitcnt == 4'd9 ? ST_ACK : ST_SHIFT;
                end else if (timeout) begin
                    clk_oe    <= 1'b0;
                    dat_oe    <= 1'b0;
                    cmd_error <= 1'b1;
                    state     <= ST_ERR;
                end
                ST_ACK: if (fe) begin
                    cmd_error <= data_sync;
                    state     <= data_sync ? ST_ERR : ST_WAIT_IDLE;
                end else if (timeout) begin
                    clk_oe    <= 1'b0;
                    dat_oe    <= 1'b0;
                    cmd_error <= 1'b1;
                    state     <= ST_ERR;
                end
                ST_WAIT_IDLE: begin
                    idle_seen <= clock_sync & data_sync;
                    if (clock_sync && data_sync && idle_seen) begin
                        cmd_done <= 1'b1;
                        state    <= ST_DONE;
                    end else if (timeout) begin
                        clk_oe    <= 1'b0;
                        dat_oe    <= 1'b0;
                        cmd_error <= 1'b1;
                        state     <= ST_ERR;
                    end
                end
                ST_DONE, ST_ERR: begin
                    cmd_busy <= 1'b0;
                    state    <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: directed bench with a pulled-up PS/2 device model and a frame-level reference
module tb_ps2_host_tx;

    localparam int INH  = 20;
    localparam int TMO  = 200;
    localparam int HALF = 20;

    logic       inclock  = 1'b0;
    logic       resetn   = 1'b0;
    logic       cmd_send = 1'b0;
    logic [7:0] cmd_data = 8'h00;
    logic       cmd_busy;
    logic       cmd_done;
    logic       cmd_error;
    logic       tx_active;
    wire        ps2_clock;
    wire        ps2_data;
    logic       dev_clk_low = 1'b0;
    logic       dev_dat_low = 1'b0;
    int         vectors     = 0;
    int         miscompares = 0;
    int         ndone       = 0;
    int         nerr        = 0;
    logic       pulse_prev  = 1'b0;
    logic [10:0] s;

    pullup (ps2_clock);
    pullup (ps2_data);
    assign ps2_clock = dev_clk_low ? 1'b0 : 1'bz;
    assign ps2_data  = dev_dat_low ? 1'b0 : 1'bz;

    ps2_host_tx #(
        .INHIBIT_CYCLES (INH),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .inclock   (inclock),
        .resetn    (resetn),
        .cmd_data  (cmd_data),
        .cmd_send  (cmd_send),
        .cmd_busy  (cmd_busy),
        .cmd_done  (cmd_done),
        .cmd_error (cmd_error),
        .tx_active (tx_active),
        .ps2_clock (ps2_clock),
        .ps2_data  (ps2_data)
    );

    always #5 inclock = ~inclock;

    // what the device must see on its rising edges: start, data LSB first, odd parity, stop
    function automatic logic [10:0] frame_of(input logic [7:0] d);
        logic [10:0] f;
        int ones;
        ones = 0;
        f[0] = 1'b0;
        for (int i = 0; i < 8; i++) begin
            f[i+1] = d[i];
            ones += int'(d[i]);
        end
        f[9]  = (ones % 2 == 0);
        f[10] = 1'b1;
        return f;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // advance one cycle and check the per-cycle handshake rules
    task automatic tick();
        @(negedge inclock);
        chk("tx_active_eq_busy", tx_active, cmd_busy);
        chk("done_err_exclusive", cmd_done & cmd_error, 0);
        if (pulse_prev) begin
            chk("busy_after_pulse", cmd_busy, 0);
            chk("pulse_one_cycle", cmd_done | cmd_error, 0);
        end
        if (cmd_done || cmd_error) chk("busy_in_pulse", cmd_busy, 1);
        ndone += int'(cmd_done);
        nerr  += int'(cmd_error);
        pulse_prev = cmd_done | cmd_error;
    endtask

    task automatic chk_released(input string name);
        chk({name, "_clock"}, ps2_clock, 1);
        chk({name, "_data"}, ps2_data, 1);
    endtask

    // mode 0: device ACKs, 1: NACK, 2: device never clocks, 3: poke 0x55 then reset after edge 5
    task automatic xfer(input logic [7:0] d, input int mode, output logic [10:0] fr);
        int n, low_at, d0, e0, k;
        fr = '0;
        tick();
        d0 = ndone;
        e0 = nerr;
        cmd_data = d;
        cmd_send = 1'b1;
        tick();
        cmd_send = 1'b0;
        chk("accept_busy", cmd_busy, 1);
        n = 0;
        low_at = 0;
        while (ps2_clock === 1'b0 && n < 100) begin
            n++;
            if (low_at == 0 && ps2_data === 1'b0) low_at = n;
            tick();
        end
        chk("inhibit_len", n, INH + 1);
        chk("rts_data_low_at", low_at, INH + 1);
        fr[0] = ps2_data;
        if (mode == 2) begin
            k = 0;
            while (nerr == e0 && k < 2 * TMO) begin
                tick();
                k++;
            end
            chk("timeout_cycles", k, TMO);
            chk("timeout_no_done", ndone - d0, 0);
            chk_released("timeout_release");
            return;
        end
        repeat (10) tick();
        for (int i = 1; i <= 10; i++) begin
            dev_clk_low = 1'b1;
            for (int t = 0; t < HALF; t++) begin
                if (mode == 3 && i == 2) begin
                    cmd_send = (t == 0);
                    cmd_data = 8'h55;
                end
                tick();
            end
            cmd_send = 1'b0;
            dev_clk_low = 1'b0;
            fr[i] = ps2_data;
            if (mode == 3 && i == 5) begin
                chk("busy_mid_frame", cmd_busy, 1);
                chk("pre_reset_data_low", ps2_data, 0);
                resetn = 1'b0;
                #1;
                chk_released("async_reset_release");
                chk("reset_busy", cmd_busy, 0);
                chk("reset_done", cmd_done, 0);
                chk("reset_error", cmd_error, 0);
                chk("reset_tx_active", tx_active, 0);
                repeat (3) tick();
                resetn = 1'b1;
                tick();
                return;
            end
            repeat (HALF) tick();
        end
        dev_dat_low = (mode == 0);
        repeat (5) tick();
        dev_clk_low = 1'b1;
        repeat (HALF) tick();
        dev_clk_low = 1'b0;
        repeat (2) tick();
        dev_dat_low = 1'b0;
        k = 0;
        while ((ndone - d0) + (nerr - e0) == 0 && k < 60) begin
            tick();
            k++;
        end
        chk("done_count", ndone - d0, mode == 0 ? 1 : 0);
        chk("error_count", nerr - e0, mode == 1 ? 1 : 0);
        tick();
        chk("busy_after_end", cmd_busy, 0);
        chk_released("end_release");
    endtask

    initial begin
        repeat (3) tick();
        chk("rst_busy", cmd_busy, 0);
        chk("rst_done", cmd_done, 0);
        chk("rst_error", cmd_error, 0);
        chk("rst_tx_active", tx_active, 0);
        chk_released("rst_lines");
        resetn = 1'b1;
        repeat (2) tick();

        xfer(8'hED, 0, s);
        chk("frame_ED_literal", s, 11'h7DA);
        chk("frame_ED_model", s, frame_of(8'hED));

        xfer(8'h01, 0, s);
        chk("frame_01_literal", s, 11'h402);
        chk("frame_01_model", s, frame_of(8'h01));

        xfer(8'hFF, 1, s);
        chk("frame_FF_literal", s, 11'h7FE);
        chk("frame_FF_model", s, frame_of(8'hFF));

        xfer(8'hF3, 2, s);
        chk("timeout_start_bit", s[0], 0);

        xfer(8'hED, 3, s);
        chk("abort_prefix_literal", s[5:0], 6'h1A);
        chk("abort_prefix_model", s[5:0], frame_of(8'hED) & 11'h03F);

        xfer(8'hED, 0, s);
        chk("frame_ED_after_reset", s, frame_of(8'hED));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
